vector_serializer: RTL

Parallel-to-serial transmitter for the team's serial vector link: accepts a WIDTH-bit word and shifts it out one bit per enabled cycle, LSB first. This matches the bit order of our serial-to-vector collector, which writes bit index 0 first. A one-entry holding register allows back-to-back words with no idle gap. Frame markers (ofirst, odone) let the receiving end align its bit counter.

---
 rtl/vector_serializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vector_serializer.sv
// vector_serializer: parallel-to-serial transmitter, LSB first, with a
// one-entry holding register so consecutive words stream without a gap.
// ofirst flags bit 0 of every word; odone pulses as the last bit retires.
module vector_serializer #(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             iclk,
   input  logic             ireset,
   input  logic [WIDTH-1:0] iValor,
   input  logic             iload,
   input  logic             ienable,
   output logic             osenal,
   output logic             oready,
   output logic             ofirst,
   output logic             odone
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_hold;
   logic [CW-1:0]    r_cnt;
   logic             r_pending;
   logic             r_senal;
   logic             r_first;
   logic             r_done;

   logic             w_accept;
   logic             w_last_adv;
   logic             w_start_in;
   logic             w_start_hold;
   logic             w_park;
   logic [CW-1:0]    w_cnt_nxt;

   // A word can be taken whenever the holding register is empty.
   assign w_accept     = iload & ~r_pending;
   // Retiring the final bit of the word currently on the line.
   assign w_last_adv   = (r_state == SHIFT) & ienable & (r_cnt == LAST);
   // Held word goes out first; a fresh word starts directly only if nothing is held.
   assign w_start_hold = w_last_adv & r_pending;
   assign w_start_in   = w_accept & ((r_state == IDLE) | w_last_adv);
   // Any other accept while shifting parks the word in the holding register.
   assign w_park       = w_accept & (r_state == SHIFT) & ~w_last_adv;
   assign w_cnt_nxt    = r_cnt + CW'(1);

   assign osenal = r_senal;
   assign oready = ~r_pending;
   assign ofirst = r_first;
   assign odone  = r_done;

   // Data registers: shift word and holding word, no reset needed.
   always_ff @(posedge iclk) begin
      if (w_start_hold) begin
         r_sh <= r_hold;
      end else if (w_start_in) begin
         r_sh <= iValor;
      end
      if (w_park) begin
         r_hold <= iValor;
      end
   end

   // Control FSM with registered serial output and frame markers.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         r_state   <= IDLE;
         r_pending <= 1'b0;
         r_cnt     <= '0;
         r_senal   <= IDLE_LEVEL;
         r_first   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_in) begin
                  r_cnt   <= '0;
                  r_senal <= iValor[0];
                  r_first <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_last_adv) begin
                  r_done <= 1'b1;
                  r_cnt  <= '0;
                  if (w_start_hold) begin
                     r_senal   <= r_hold[0];
                     r_first   <= 1'b1;
                     r_pending <= 1'b0;
                  end else if (w_start_in) begin
                     r_senal <= iValor[0];
                     r_first <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_senal <= IDLE_LEVEL;
                     r_first <= 1'b0;
                  end
               end else begin
                  if (ienable) begin
                     r_cnt   <= w_cnt_nxt;
                     r_senal <= r_sh[w_cnt_nxt];
                     r_first <= 1'b0;
                  end
                  if (w_park) begin
                     r_pending <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
